// File: rtl/sysid_ext.sv
// -----------------------------------------------------------------------------
// sysid_ext
//
// Avalon-MM read/write system-ID slave. It returns a fixed ID word and a build
// timestamp, holds a software scratch register and publishes a capability
// word. When built with the optional counters it also provides:
//   - a free-running 64-bit cycle counter, read coherently through CYCLE_LO
//     (which snapshots the upper half) and CYCLE_HI,
//   - a seconds uptime counter driven by a CLK_FREQ_HZ prescaler,
//   - a CTRL word whose bit 0 clears all counter state.
//
// Optional feature macro: SYSID_EXT_COUNTERS_EN
//   defined   : cycle counter, prescaler, UPTIME_SEC, hi_shadow and CTRL clear
//               are built, CAPS bit 0 = 1.
//   undefined : none of that logic exists; words 4-6 read 0, CTRL writes are
//               ignored, CAPS bit 0 = 0.
//
// Register map (word address):
//   0 ID          RO  ID_VALUE
//   1 TIMESTAMP   RO  TIMESTAMP
//   2 SCRATCH     RW  byte-lane writes
//   3 CAPS        RO  {16'h5E1D, ADDR_W[7:0], 7'b0, counters_present}
//   4 UPTIME_SEC  RO  seconds since reset/clear
//   5 CYCLE_LO    RO  cycle[31:0]; latches cycle[63:32] into hi_shadow
//   6 CYCLE_HI    RO  hi_shadow
//   7 CTRL        WO  bit 0 (with byteenable[0]) clears the counters
//   8+            reads 0, writes ignored
//
// Handshake: the slave is always ready (no waitrequest). Every cycle in which
// read is high is one accepted read transfer; its response appears exactly one
// cycle later with readdatavalid high for that single cycle. Every cycle in
// which write is high is one accepted write, committed at that clock edge.
// readdata holds its previous value while readdatavalid is low. A reset
// sampled together with a read cancels that read's response.
//
// Ports:
//   clock          single clock for all logic
//   reset          synchronous, active-high reset
//   address        word address (ADDR_W bits, ADDR_W >= 3)
//   read / write   transfer strobes
//   writedata      write data
//   byteenable     write byte lanes
//   readdata       registered read data
//   readdatavalid  one-cycle response strobe
//
// Parameters: ID_VALUE, TIMESTAMP, CLK_FREQ_HZ (>= 2), ADDR_W (>= 3).
// -----------------------------------------------------------------------------
module sysid_ext #(
  parameter logic [31:0] ID_VALUE    = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP   = 32'd0,
  parameter int          CLK_FREQ_HZ = 50_000_000,
  parameter int          ADDR_W      = 3
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [ADDR_W-1:0] address,
  input  logic              read,
  input  logic              write,
  input  logic [31:0]       writedata,
  input  logic [3:0]        byteenable,
  output logic [31:0]       readdata,
  output logic              readdatavalid
);

`ifdef SYSID_EXT_COUNTERS_EN
  localparam logic COUNTERS_PRESENT = 1'b1;
`else
  localparam logic COUNTERS_PRESENT = 1'b0;
`endif

  localparam logic [31:0] CAPS_VALUE =
    {16'h5E1D, 8'(ADDR_W), 7'd0, COUNTERS_PRESENT};

  localparam logic [2:0] W_ID     = 3'd0;
  localparam logic [2:0] W_TSTAMP = 3'd1;
  localparam logic [2:0] W_SCRATCH = 3'd2;
  localparam logic [2:0] W_CAPS   = 3'd3;
  localparam logic [2:0] W_UPTIME = 3'd4;
  localparam logic [2:0] W_CYC_LO = 3'd5;
  localparam logic [2:0] W_CYC_HI = 3'd6;
  localparam logic [2:0] W_CTRL   = 3'd7;

  // ---------------------------------------------------------------------------
  // Address decode. Only words 0-7 are mapped; anything wider than 3 bits with
  // a non-zero upper part is unmapped. Zero-extending to 32 bits keeps the
  // compare legal for ADDR_W = 3 where no upper bits exist.
  // ---------------------------------------------------------------------------
  logic [31:0] addr_ext;
  logic        in_map;
  logic [2:0]  word;

  assign addr_ext = 32'(address);
  assign in_map   = (addr_ext < 32'd8);
  assign word     = address[2:0];

  logic wr_scratch;
  assign wr_scratch = write && in_map && (word == W_SCRATCH);

  // ---------------------------------------------------------------------------
  // Scratch register
  // ---------------------------------------------------------------------------
  logic [31:0] scratch;

  always_ff @(posedge clock) begin
    if (reset) begin
      scratch <= '0;
    end else if (wr_scratch) begin
      for (int i = 0; i < 4; i++) begin
        if (byteenable[i]) scratch[8*i +: 8] <= writedata[8*i +: 8];
      end
    end
  end

`ifdef SYSID_EXT_COUNTERS_EN
  // ---------------------------------------------------------------------------
  // Counters. A CTRL clear and reset share one path so they have identical
  // effect on counter state; the clear takes priority over a same-cycle
  // prescaler terminal count and over a same-cycle hi_shadow capture.
  // ---------------------------------------------------------------------------
  localparam logic [31:0] PRESC_LAST = 32'(CLK_FREQ_HZ - 1);

  logic [63:0] cycle;
  logic [31:0] presc;
  logic [31:0] uptime;
  logic [31:0] hi_shadow;
  logic        ctrl_clear;
  logic        presc_tc;
  logic        rd_cyc_lo;

  assign ctrl_clear = write && in_map && (word == W_CTRL) &&
                      byteenable[0] && writedata[0];
  assign presc_tc   = (presc == PRESC_LAST);
  assign rd_cyc_lo  = read && in_map && (word == W_CYC_LO);

  always_ff @(posedge clock) begin
    if (reset || ctrl_clear) begin
      cycle     <= '0;
      presc     <= '0;
      uptime    <= '0;
      hi_shadow <= '0;
    end else begin
      cycle <= cycle + 64'd1;
      if (presc_tc) begin
        presc  <= '0;
        uptime <= uptime + 32'd1;
      end else begin
        presc  <= presc + 32'd1;
      end
      // Snapshot the upper half in the same cycle the lower half is returned,
      // so a later CYCLE_HI read pairs with this CYCLE_LO value.
      if (rd_cyc_lo) hi_shadow <= cycle[63:32];
    end
  end
`endif

  // ---------------------------------------------------------------------------
  // Read mux (combinational, pre-write values) and registered response
  // ---------------------------------------------------------------------------
  logic [31:0] rd_mux;

  always_comb begin
    rd_mux = '0;
    if (in_map) begin
      case (word)
        W_ID:      rd_mux = ID_VALUE;
        W_TSTAMP:  rd_mux = TIMESTAMP;
        W_SCRATCH: rd_mux = scratch;
        W_CAPS:    rd_mux = CAPS_VALUE;
`ifdef SYSID_EXT_COUNTERS_EN
        W_UPTIME:  rd_mux = uptime;
        W_CYC_LO:  rd_mux = cycle[31:0];
        W_CYC_HI:  rd_mux = hi_shadow;
`endif
        default:   rd_mux = '0;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      readdatavalid <= read;
      if (read) readdata <= rd_mux;
    end
  end

endmodule

// File: tb/tb_sysid_ext.sv
// -----------------------------------------------------------------------------
// tb_sysid_ext
//
// Bench for sysid_ext. The reference model describes counter state as
// "elapsed cycles since the last origin" (reset release, CTRL clear, or a
// forced counter value), so expected counter words come from subtraction and
// division rather than from a step-by-step register copy.
// -----------------------------------------------------------------------------
module tb_sysid_ext;

  localparam logic [31:0] ID = 32'h1234_5678;
  localparam logic [31:0] TS = 32'd1392159199;
  localparam int unsigned F  = 4;
  localparam int          AW = 4;

`ifdef SYSID_EXT_COUNTERS_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic          clock;
  logic          reset;
  logic [AW-1:0] address;
  logic          read;
  logic          write;
  logic [31:0]   writedata;
  logic [3:0]    byteenable;
  logic [31:0]   readdata;
  logic          readdatavalid;

  sysid_ext #(
    .ID_VALUE   (ID),
    .TIMESTAMP  (TS),
    .CLK_FREQ_HZ(F),
    .ADDR_W     (AW)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .readdata     (readdata),
    .readdatavalid(readdatavalid)
  );

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Index of the current clock cycle, valid between posedges.
  int unsigned tcyc = 0;
  always @(posedge clock) tcyc <= tcyc + 1;

  // ---------------------------------------------------------------------------
  // Reference model state
  // ---------------------------------------------------------------------------
  logic [31:0]     m_scratch;
  logic [31:0]     m_hi;
  longint unsigned cyc_v;   // cycle counter value at cycle cyc_t
  int unsigned     cyc_t;
  int unsigned     up_t;    // cycle at which prescaler/uptime were last zero

  logic [31:0] exp_q[$];
  int          checks   = 0;
  int          failures = 0;
  bit          mon_en   = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at cycle %0d", tag, got, exp, tcyc);
    end
  endtask

  function automatic longint unsigned m_cycle();
    return cyc_v + longint'(tcyc - cyc_t);
  endfunction

  function automatic logic [31:0] m_read(input int a);
    longint unsigned c;
    c = m_cycle();
    if (a >= 8) return 32'd0;
    case (a)
      0: return ID;
      1: return TS;
      2: return m_scratch;
      3: return {16'h5E1D, 8'(AW), 7'd0, CNT_EN};
      4: return CNT_EN ? 32'((tcyc - up_t) / F) : 32'd0;
      5: return CNT_EN ? c[31:0] : 32'd0;
      6: return CNT_EN ? m_hi : 32'd0;
      default: return 32'd0;
    endcase
  endfunction

  task automatic m_clear_counters(input int unsigned at);
    cyc_t = at;
    cyc_v = 64'd0;
    up_t  = at;
    m_hi  = 32'd0;
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks (called at a negedge, return at the next negedge)
  // ---------------------------------------------------------------------------
  task automatic bus(input bit rd, input bit wr, input int a,
                     input logic [31:0] wd, input logic [3:0] be);
    longint unsigned c;
    read       = rd;
    write      = wr;
    address    = a[AW-1:0];
    writedata  = wd;
    byteenable = be;
    if (rd) begin
      exp_q.push_back(m_read(a));
      if (a == 5 && CNT_EN) begin
        c    = m_cycle();
        m_hi = c[63:32];
      end
    end
    if (wr) begin
      if (a == 2) begin
        for (int i = 0; i < 4; i++)
          if (be[i]) m_scratch[8*i +: 8] = wd[8*i +: 8];
      end
      if (a == 7 && CNT_EN && be[0] && wd[0]) m_clear_counters(tcyc + 1);
    end
    @(negedge clock);
  endtask

  task automatic rd_word(input int a);
    bus(1'b1, 1'b0, a, 32'd0, 4'd0);
  endtask

  task automatic wr_word(input int a, input logic [31:0] wd, input logic [3:0] be);
    bus(1'b0, 1'b1, a, wd, be);
  endtask

  task automatic idle(input int n);
    read  = 1'b0;
    write = 1'b0;
    repeat (n) @(negedge clock);
  endtask

  // Holds reset for n cycles; a read already on the bus stays for the first
  // reset cycle so that its response is cancelled.
  task automatic do_reset(input int n);
    reset = 1'b1;
    @(negedge clock);
    read  = 1'b0;
    write = 1'b0;
    repeat (n - 1) @(negedge clock);
    check("reset_readdata", readdata, 32'd0);
    check("reset_rdvalid", {31'd0, readdatavalid}, 32'd0);
    reset = 1'b0;
    m_clear_counters(tcyc);
    m_scratch = 32'd0;
    exp_q.delete();
    mon_en = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  // Scoreboard: each read must be answered exactly one cycle later.
  // ---------------------------------------------------------------------------
  always @(posedge clock) begin
    #1;
    if (mon_en) begin
      if (exp_q.size() > 0) begin
        check("rdvalid", {31'd0, readdatavalid}, 32'd1);
        check("rdata", readdata, exp_q.pop_front());
      end else begin
        check("rdvalid_idle", {31'd0, readdatavalid}, 32'd0);
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    reset      = 1'b1;
    read       = 1'b0;
    write      = 1'b0;
    address    = '0;
    writedata  = '0;
    byteenable = '0;
    m_scratch  = '0;
    m_clear_counters(0);

    @(negedge clock);
    do_reset(3);

    // Identity words and capability, back to back.
    for (int a = 0; a < 4; a++) rd_word(a);
    idle(1);

    // Scratch byte lanes and read-during-write.
    wr_word(2, 32'hDEAD_BEEF, 4'b1111);
    wr_word(2, 32'h0000_0011, 4'b0001);
    rd_word(2);
    bus(1'b1, 1'b1, 2, 32'hCAFE_F00D, 4'b1111);
    rd_word(2);
    wr_word(2, 32'h5500_AA00, 4'b1010);
    rd_word(2);
    // Writes to read-only / unmapped words are ignored.
    wr_word(0, 32'hFFFF_FFFF, 4'b1111);
    wr_word(12, 32'hFFFF_FFFF, 4'b1111);
    rd_word(0);
    idle(2);

    // Back-to-back mixed mapped / unmapped reads.
    rd_word(0); rd_word(1); rd_word(7); rd_word(9);
    idle(2);

    // Counter words right after reset and at the uptime boundary.
    do_reset(2);
    rd_word(5);
    idle(7);
    for (int i = 0; i < 4; i++) rd_word(4);
    rd_word(5);
    idle(1);

    // CTRL clear in the cycle of a prescaler terminal count.
    while (((tcyc - up_t) % F) != F - 1) @(negedge clock);
    wr_word(7, 32'h0000_0001, 4'b0001);
    rd_word(4);
    rd_word(5);
    // Clear with lane 0 disabled is ignored.
    idle(9);
    wr_word(7, 32'hFFFF_FFFF, 4'b1110);
    rd_word(4);
    rd_word(7);
    idle(2);

`ifdef SYSID_EXT_COUNTERS_EN
    // Coherent 64-bit read across a low-word wrap.
    force dut.cycle = 64'h0000_0000_FFFF_FFFE;
    release dut.cycle;
    cyc_v = 64'h0000_0000_FFFF_FFFE;
    cyc_t = tcyc;
    rd_word(5);
    idle(5);
    rd_word(6);
    rd_word(5);
    rd_word(6);
    idle(2);
`endif

    // Randomised traffic.
    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        idle($urandom_range(1, 3));
      end else begin
        bus(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0),
            int'($urandom_range(0, 15)), $urandom, 4'($urandom_range(0, 15)));
      end
    end
    idle(2);

    // Reset sampled with a read in flight cancels its response.
    rd_word(0);
    idle(1);
    read    = 1'b1;
    address = 4'd1;
    do_reset(2);
    rd_word(2);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
